// File: rtl/ex_mem_pkg.sv
// Shared widths, pipeline entry layout and load/store size encodings for the EX/MEM boundary.
package ex_mem_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [XLEN-1:0]   alu_res;
      logic [XLEN-1:0]   st_data;
      logic [REG_AW-1:0] rd;
      logic              reg_we;
      logic              mem_rd;
      logic              mem_wr;
      logic [2:0]        funct3;
   } ex_mem_entry_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // x0 is hardwired to zero, so a write to it is never allowed to reach writeback.
   function automatic logic wb_allowed(input logic [REG_AW-1:0] rd, input logic we);
      return we && (rd != '0);
   endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Generic two-entry skid buffer with flush; 1-cycle latency, full throughput.
// in_ready is a pure flop (!skid_valid), so downstream stalls never reach upstream combinationally.
module ex_mem_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         out_valid_q, out_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         in_xfer;
   logic         out_free;

   assign in_xfer  = in_valid && !skid_valid_q;
   assign out_free = !out_valid_q || out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_data_d   = out_data_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            if (in_xfer) out_data_d = in_data;
            out_valid_d = in_xfer;
         end
      end else if (in_xfer) begin
         // Output is held: park the accepted entry behind it.
         skid_data_d  = in_data;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready  = !skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register over a skid buffer: x0 write suppression and gating of side-effect bits when empty.
// Optional EX_MEM_STALL_CNT_EN adds a saturating stall_cnt output counting held-output cycles.
module ex_mem_stage #(
   parameter int XLEN   = ex_mem_pkg::XLEN,
   parameter int REG_AW = ex_mem_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_alu_res,
   input  logic [XLEN-1:0]   in_st_data,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_reg_we,
   input  logic              in_mem_rd,
   input  logic              in_mem_wr,
   input  logic [2:0]        in_funct3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_alu_res,
   output logic [XLEN-1:0]   out_st_data,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_we,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   output logic [2:0]        out_funct3
`ifdef EX_MEM_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   import ex_mem_pkg::*;

   // Entry field widths follow the package; override XLEN/REG_AW only together with it.
   ex_mem_entry_t in_ent;
   ex_mem_entry_t out_ent;

   always_comb begin
      in_ent         = '0;
      in_ent.alu_res = in_alu_res;
      in_ent.st_data = in_st_data;
      in_ent.rd      = in_rd;
      in_ent.reg_we  = wb_allowed(in_rd, in_reg_we);
      in_ent.mem_rd  = in_mem_rd;
      in_ent.mem_wr  = in_mem_wr;
      in_ent.funct3  = in_funct3;
   end

   ex_mem_skid #(.W($bits(ex_mem_entry_t))) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_ent),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_ent)
   );

   assign out_alu_res = out_ent.alu_res;
   assign out_st_data = out_ent.st_data;
   assign out_rd      = out_ent.rd;
   assign out_mem_rd  = out_ent.mem_rd;
   assign out_funct3  = out_ent.funct3;
   // A stale or flushed entry must never write memory or the register file.
   assign out_reg_we  = out_valid && out_ent.reg_we;
   assign out_mem_wr  = out_valid && out_ent.mem_wr;

`ifdef EX_MEM_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
